game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Parametrised game-flow controller for the rhythm game. It sequences a session from title screen through play to a win or lose screen. It accumulates misses in a saturating counter with a configurable limit and a Master-mode step size, and offers a one-shot timed recovery chance. It sits between the debounced key/judge logic and the VGA screen-select and HUD miss display.

## Interface
Parameters:
- MISS_W, 3: width of `total_miss`.
- MAX_MISS, 7: miss count at which the game is lost. Must satisfy MAX_MISS ≤ 2**MISS_W−1.
- MASTER_STEP, 2: miss increment while `master`=1. Normal mode increment is 1.
- RECOVER_AT, 5: count at or above which the recovery chance opens.
- CHANCE_CYCLES, 1024: recovery window length in clk cycles. Must be ≥1.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- start_key  in  1  debounced start key, level
- quit_key  in  1  debounced quit/acknowledge key, level
- miss  in  1  judge miss flag, level; each rising edge is one miss
- recover  in  1  recovery-hit flag, level; rising edge counts
- master  in  1  Master difficulty select, sampled on every miss edge
- done  in  1  song-finished flag, level
- interface_en  out  1  title screen select
- map_en  out  1  play-field select
- chance  out  1  recovery window open
- win  out  1  win screen select
- lose  out  1  lose screen select
- total_miss  out  MISS_W  current miss count, for the HUD

## Operation
- Edge detection is internal. Each of start_key, quit_key, miss and recover has a previous-value register. A rise is in=1 and prev=0; a fall is in=0 and prev=1.
- States: IDLE, PLAY, CHANCE, WIN, LOSE.
- IDLE:
  - Rise on start_key → PLAY.
  - Count cleared.
- PLAY and CHANCE apply these priorities each cycle, highest first:
  - Rise on quit_key → IDLE, count cleared.
  - done=1 → WIN, count frozen.
  - Rise on miss → count += (master ? MASTER_STEP : 1). The sum is computed in MISS_W+1 bits and saturates at MAX_MISS.
- Exit from PLAY after a miss:
  - New count = MAX_MISS → LOSE.
  - Else new count ≥ RECOVER_AT and the chance is still unused this game → CHANCE. Timer loads CHANCE_CYCLES−1 and the chance is marked used.
- CHANCE:
  - Rise on recover → count −1, → PLAY.
  - Rise on miss without recover → miss applied as above, → PLAY, or → LOSE if saturated.
  - Rise on both in the same cycle → count unchanged, → PLAY.
  - Timer reaches 0 → PLAY, count unchanged.
- WIN and LOSE:
  - Fall on quit_key (key released) → IDLE, count cleared.
  - All other inputs are ignored.
- The chance-used flag clears on entry to IDLE.
- Outputs decoded from the registered state:
  - interface_en = IDLE
  - map_en = PLAY or CHANCE
  - chance = CHANCE
  - win = WIN
  - lose = LOSE
- total_miss equals the counter in all states. It shows MAX_MISS in LOSE and holds its value in WIN.

## Timing
- All state and outputs are registered.
- An input edge present at clk edge k updates state and outputs at edge k. The change is visible during cycle k+1.
- A held level does not re-trigger. Misses need a 0→1 transition each.
- Reset (resetn=0 at an edge, in any state, mid-game included) forces:
  - state IDLE, interface_en=1, other outputs 0, total_miss=0
  - timer 0, chance-used 0, edge registers 0
- Reset takes precedence over every event.
- The CHANCE timeout and a recover edge in the same cycle resolve as recover.

## Configuration
- GAME_FLOW_CHANCE_EN:
  - Defined: CHANCE state, timer and chance-used flag are compiled in.
  - Undefined: CHANCE is unreachable, `recover` is ignored and `chance` is tied 0. PLAY goes directly to LOSE at MAX_MISS.

## Structure
- Shared package game_pkg holds:
  - the typedef enum for flow states (IDLE, PLAY, CHANCE, WIN, LOSE)
  - default constants for MAX_MISS, RECOVER_AT and MASTER_STEP
- Sub-module game_edge_det: one-bit previous-value register with rise/fall outputs, reset by resetn. Instantiated four times.

## Test plan
- Reset, then start_key pulse → interface_en 1→0, map_en=1, total_miss=0, one cycle after the edge.
- Normal mode, MAX_MISS=7, macro undefined, 7 miss pulses → total_miss 1..6, then 7 with lose=1, map_en=0. quit_key press then release → IDLE on the release, total_miss=0.
- Master=1, macro defined → misses give total_miss 2, then 4, then 6 with chance=1. Next miss → 7, chance=0, lose=1.
- Normal mode, 5 misses → chance=1. recover pulse → total_miss=4, chance=0. Next miss → 5 with no chance (one-shot).
- CHANCE_CYCLES=16, reach 5, no stimulus → chance high exactly 16 cycles, then PLAY with total_miss=5.
- At count 3, done and a miss rise in the same cycle → win=1, total_miss=3 held. Separately, quit_key rise mid-PLAY at count 2 → IDLE, total_miss=0. resetn low mid-CHANCE → IDLE, all outputs at reset values.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and default constants for the rhythm-game flow controller.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PLAY   = 3'd1,
    CHANCE = 3'd2,
    WIN    = 3'd3,
    LOSE   = 3'd4
  } flow_state_t;

  localparam int DEF_MAX_MISS    = 7;
  localparam int DEF_RECOVER_AT  = 5;
  localparam int DEF_MASTER_STEP = 2;

endpackage

// File: rtl/game_edge_det.sv
// One-bit previous-value register producing combinational rise/fall strobes.
module game_edge_det (
  input  logic clk,
  input  logic resetn,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (!resetn) r_prev <= 1'b0;
    else         r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;
  assign o_fall = ~i_d & r_prev;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow controller: title -> play -> win/lose with saturating miss count.
// GAME_FLOW_CHANCE_EN compiles in the one-shot timed recovery (CHANCE) state.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int MISS_W        = 3,
  parameter int MAX_MISS      = DEF_MAX_MISS,
  parameter int MASTER_STEP   = DEF_MASTER_STEP,
  parameter int RECOVER_AT    = DEF_RECOVER_AT,
  parameter int CHANCE_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start_key,
  input  logic              quit_key,
  input  logic              miss,
  input  logic              recover,
  input  logic              master,
  input  logic              done,
  output logic              interface_en,
  output logic              map_en,
  output logic              chance,
  output logic              win,
  output logic              lose,
  output logic [MISS_W-1:0] total_miss,
  output flow_state_t       o_dbg_state
);

  localparam int                TW           = (CHANCE_CYCLES > 1) ? $clog2(CHANCE_CYCLES) : 1;
  localparam logic [MISS_W-1:0] L_MAX        = MISS_W'(MAX_MISS);
  localparam logic [MISS_W-1:0] L_RECOVER    = MISS_W'(RECOVER_AT);
  localparam logic [MISS_W:0]   L_STEP_M     = (MISS_W+1)'(MASTER_STEP);
  localparam logic [MISS_W:0]   L_STEP_N     = (MISS_W+1)'(1);
  localparam logic [TW-1:0]     L_TIMER_LOAD = TW'(CHANCE_CYCLES - 1);

  logic w_start_rise, w_start_fall, w_quit_rise, w_quit_fall;
  logic w_miss_rise, w_miss_fall, w_recover_rise, w_recover_fall;

  game_edge_det u_start_edge   (.clk(clk), .resetn(resetn), .i_d(start_key), .o_rise(w_start_rise),   .o_fall(w_start_fall));
  game_edge_det u_quit_edge    (.clk(clk), .resetn(resetn), .i_d(quit_key),  .o_rise(w_quit_rise),    .o_fall(w_quit_fall));
  game_edge_det u_miss_edge    (.clk(clk), .resetn(resetn), .i_d(miss),      .o_rise(w_miss_rise),    .o_fall(w_miss_fall));
  game_edge_det u_recover_edge (.clk(clk), .resetn(resetn), .i_d(recover),   .o_rise(w_recover_rise), .o_fall(w_recover_fall));

  flow_state_t       r_state, w_next_state;
  logic [MISS_W-1:0] r_count, w_next_count, w_miss_cnt;
  logic [MISS_W:0]   w_sum;
  logic              r_interface_en, r_map_en, r_win, r_lose;
  logic              w_unused;

  // One extra bit keeps the sum from wrapping before saturation.
  assign w_sum      = {1'b0, r_count} + (master ? L_STEP_M : L_STEP_N);
  assign w_miss_cnt = (w_sum >= {1'b0, L_MAX}) ? L_MAX : w_sum[MISS_W-1:0];

`ifdef GAME_FLOW_CHANCE_EN
  logic [TW-1:0] r_timer, w_next_timer;
  logic          r_used, w_next_used, r_chance;
  assign w_unused = &{1'b0, w_recover_fall, w_start_fall, w_miss_fall};
`else
  assign w_unused = &{1'b0, w_recover_rise, w_recover_fall, w_start_fall, w_miss_fall,
                      L_RECOVER, L_TIMER_LOAD};
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
`ifdef GAME_FLOW_CHANCE_EN
    w_next_timer = r_timer;
    w_next_used  = r_used;
`endif
    case (r_state)
      IDLE: begin
        w_next_count = '0;
        if (w_start_rise) w_next_state = PLAY;
      end
      PLAY: begin
        if (w_quit_rise) begin
          w_next_state = IDLE;
          w_next_count = '0;
        end else if (done) begin
          w_next_state = WIN;
        end else if (w_miss_rise) begin
          w_next_count = w_miss_cnt;
          if (w_miss_cnt == L_MAX) begin
            w_next_state = LOSE;
          end
`ifdef GAME_FLOW_CHANCE_EN
          else if ((w_miss_cnt >= L_RECOVER) && !r_used) begin
            w_next_state = CHANCE;
            w_next_timer = L_TIMER_LOAD;
            w_next_used  = 1'b1;
          end
`endif
        end
      end
`ifdef GAME_FLOW_CHANCE_EN
      CHANCE: begin
        // Recover wins over a simultaneous miss or timeout.
        if (w_quit_rise) begin
          w_next_state = IDLE;
          w_next_count = '0;
        end else if (done) begin
          w_next_state = WIN;
        end else if (w_recover_rise && w_miss_rise) begin
          w_next_state = PLAY;
        end else if (w_recover_rise) begin
          w_next_state = PLAY;
          w_next_count = r_count - MISS_W'(1);
        end else if (w_miss_rise) begin
          w_next_count = w_miss_cnt;
          w_next_state = (w_miss_cnt == L_MAX) ? LOSE : PLAY;
        end else if (r_timer == '0) begin
          w_next_state = PLAY;
        end else begin
          w_next_timer = r_timer - TW'(1);
        end
      end
`endif
      WIN, LOSE: begin
        if (w_quit_fall) begin
          w_next_state = IDLE;
          w_next_count = '0;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_count = '0;
      end
    endcase
`ifdef GAME_FLOW_CHANCE_EN
    if (w_next_state == IDLE) w_next_used = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_interface_en <= 1'b1;
      r_map_en       <= 1'b0;
      r_win          <= 1'b0;
      r_lose         <= 1'b0;
`ifdef GAME_FLOW_CHANCE_EN
      r_timer        <= '0;
      r_used         <= 1'b0;
      r_chance       <= 1'b0;
`endif
    end else begin
      r_state        <= w_next_state;
      r_count        <= w_next_count;
      r_interface_en <= (w_next_state == IDLE);
      r_map_en       <= (w_next_state == PLAY) || (w_next_state == CHANCE);
      r_win          <= (w_next_state == WIN);
      r_lose         <= (w_next_state == LOSE);
`ifdef GAME_FLOW_CHANCE_EN
      r_timer        <= w_next_timer;
      r_used         <= w_next_used;
      r_chance       <= (w_next_state == CHANCE);
`endif
    end
  end

  assign interface_en = r_interface_en;
  assign map_en       = r_map_en;
  assign win          = r_win;
  assign lose         = r_lose;
  assign total_miss   = r_count;
  assign o_dbg_state  = r_state;
`ifdef GAME_FLOW_CHANCE_EN
  assign chance       = r_chance;
`else
  assign chance       = 1'b0;
`endif

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl; outputs packed as
// {interface_en, map_en, chance, win, lose, total_miss[2:0]}.
module tb_game_flow_ctrl;
  import game_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0, start_key = 1'b0, quit_key = 1'b0, miss = 1'b0;
  logic recover = 1'b0, master = 1'b0, done = 1'b0;
  logic interface_en, map_en, chance, win, lose;
  logic [2:0] total_miss;
  flow_state_t dbg_state;
  int n_tests = 0;
  int n_fail  = 0;

  game_flow_ctrl #(
    .MISS_W(3), .MAX_MISS(7), .MASTER_STEP(2), .RECOVER_AT(5), .CHANCE_CYCLES(16)
  ) dut (
    .clk(clk), .resetn(resetn), .start_key(start_key), .quit_key(quit_key),
    .miss(miss), .recover(recover), .master(master), .done(done),
    .interface_en(interface_en), .map_en(map_en), .chance(chance),
    .win(win), .lose(lose), .total_miss(total_miss), .o_dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; start_key = 1'b0; quit_key = 1'b0; miss = 1'b0;
    recover = 1'b0; master = 1'b0; done = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic start_game();
    start_key = 1'b1; tick();
    start_key = 1'b0; tick();
  endtask

  task automatic miss_rise(input logic m);
    master = m; miss = 1'b1; tick();
  endtask

  task automatic miss_fall();
    miss = 1'b0; tick();
  endtask

  task automatic misses(input int n, input logic m);
    repeat (n) begin
      miss_rise(m);
      miss_fall();
    end
  endtask

  function automatic logic [7:0] outs();
    return {interface_en, map_en, chance, win, lose, total_miss};
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    n_tests++;
    if (outs() !== 8'b10000_000) begin
      n_fail++; $display("FAIL reset_outs: got %b want %b", outs(), 8'b10000_000);
    end
    n_tests++;
    if (dbg_state !== IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
    end
    resetn = 1'b1; tick();
    n_tests++;
    if (outs() !== 8'b10000_000) begin
      n_fail++; $display("FAIL reset_release: got %b want %b", outs(), 8'b10000_000);
    end
  endtask

  task automatic test_start();
    do_reset();
    start_key = 1'b1; tick();
    n_tests++;
    if (outs() !== 8'b01000_000) begin
      n_fail++; $display("FAIL start_play: got %b want %b", outs(), 8'b01000_000);
    end
    start_key = 1'b0; tick();
  endtask

`ifndef GAME_FLOW_CHANCE_EN
  task automatic test_normal_lose();
    logic [7:0] exp_v;
    do_reset(); start_game();
    for (int i = 1; i <= 7; i++) begin
      miss_rise(1'b0);
      exp_v = (i < 7) ? {5'b01000, 3'(i)} : {5'b00001, 3'd7};
      n_tests++;
      if (outs() !== exp_v) begin
        n_fail++; $display("FAIL normal_miss_%0d: got %b want %b", i, outs(), exp_v);
      end
      miss_fall();
    end
    quit_key = 1'b1; tick();
    n_tests++;
    if (outs() !== 8'b00001_111) begin
      n_fail++; $display("FAIL lose_quit_press: got %b want %b", outs(), 8'b00001_111);
    end
    quit_key = 1'b0; tick();
    n_tests++;
    if (outs() !== 8'b10000_000) begin
      n_fail++; $display("FAIL lose_quit_release: got %b want %b", outs(), 8'b10000_000);
    end
    misses(1, 1'b0);
    n_tests++;
    if (outs() !== 8'b10000_000) begin
      n_fail++; $display("FAIL idle_miss_ignored: got %b want %b", outs(), 8'b10000_000);
    end
  endtask
`else
  task automatic test_recover();
    do_reset(); start_game();
    misses(4, 1'b0);
    miss_rise(1'b0);
    n_tests++;
    if (outs() !== 8'b01100_101) begin
      n_fail++; $display("FAIL chance_open: got %b want %b", outs(), 8'b01100_101);
    end
    miss_fall();
    recover = 1'b1; tick();
    n_tests++;
    if (outs() !== 8'b01000_100) begin
      n_fail++; $display("FAIL recover_hit: got %b want %b", outs(), 8'b01000_100);
    end
    recover = 1'b0; tick();
    miss_rise(1'b0);
    n_tests++;
    if (outs() !== 8'b01000_101) begin
      n_fail++; $display("FAIL chance_one_shot: got %b want %b", outs(), 8'b01000_101);
    end
    miss_fall();
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    do_reset(); start_game();
    misses(4, 1'b0);
    miss_rise(1'b0);
    miss = 1'b0;
    n_tests++;
    if (outs() !== 8'b01100_101) begin
      n_fail++; $display("FAIL timeout_open: got %b want %b", outs(), 8'b01100_101);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (chance !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL timeout_window: got %0d low cycles want 0", bad);
    end
    tick();
    n_tests++;
    if (outs() !== 8'b01000_101) begin
      n_fail++; $display("FAIL timeout_expire: got %b want %b", outs(), 8'b01000_101);
    end
  endtask

  task automatic test_both();
    do_reset(); start_game();
    misses(5, 1'b0);
    recover = 1'b1; miss = 1'b1; tick();
    n_tests++;
    if (outs() !== 8'b01000_101) begin
      n_fail++; $display("FAIL recover_and_miss: got %b want %b", outs(), 8'b01000_101);
    end
    recover = 1'b0; miss = 1'b0; tick();
    miss_rise(1'b0);
    n_tests++;
    if (outs() !== 8'b01000_110) begin
      n_fail++; $display("FAIL after_both_miss: got %b want %b", outs(), 8'b01000_110);
    end
    miss_fall();
  endtask
`endif

  task automatic test_master();
    logic [7:0] exp_v [4];
`ifdef GAME_FLOW_CHANCE_EN
    exp_v = '{8'b01000_010, 8'b01000_100, 8'b01100_110, 8'b00001_111};
`else
    exp_v = '{8'b01000_010, 8'b01000_100, 8'b01000_110, 8'b00001_111};
`endif
    do_reset(); start_game();
    for (int i = 0; i < 4; i++) begin
      miss_rise(1'b1);
      n_tests++;
      if (outs() !== exp_v[i]) begin
        n_fail++; $display("FAIL master_miss_%0d: got %b want %b", i, outs(), exp_v[i]);
      end
      miss_fall();
    end
    master = 1'b0;
  endtask

  task automatic test_held_level();
    do_reset(); start_game();
    master = 1'b0; miss = 1'b1;
    repeat (4) tick();
    n_tests++;
    if (outs() !== 8'b01000_001) begin
      n_fail++; $display("FAIL held_miss: got %b want %b", outs(), 8'b01000_001);
    end
    miss_fall();
    miss_rise(1'b0);
    n_tests++;
    if (outs() !== 8'b01000_010) begin
      n_fail++; $display("FAIL second_edge: got %b want %b", outs(), 8'b01000_010);
    end
    miss_fall();
  endtask

  task automatic test_done_win();
    do_reset(); start_game();
    misses(3, 1'b0);
    done = 1'b1; miss = 1'b1; tick();
    n_tests++;
    if (outs() !== 8'b00010_011) begin
      n_fail++; $display("FAIL done_beats_miss: got %b want %b", outs(), 8'b00010_011);
    end
    miss_fall();
    miss_rise(1'b0);
    n_tests++;
    if (outs() !== 8'b00010_011) begin
      n_fail++; $display("FAIL win_miss_ignored: got %b want %b", outs(), 8'b00010_011);
    end
    miss = 1'b0; done = 1'b0; tick();
    quit_key = 1'b1; tick();
    n_tests++;
    if (outs() !== 8'b00010_011) begin
      n_fail++; $display("FAIL win_quit_press: got %b want %b", outs(), 8'b00010_011);
    end
    quit_key = 1'b0; tick();
    n_tests++;
    if (outs() !== 8'b10000_000) begin
      n_fail++; $display("FAIL win_quit_release: got %b want %b", outs(), 8'b10000_000);
    end
  endtask

  task automatic test_quit_mid();
    do_reset(); start_game();
    misses(2, 1'b0);
    quit_key = 1'b1; tick();
    n_tests++;
    if (outs() !== 8'b10000_000) begin
      n_fail++; $display("FAIL quit_mid_play: got %b want %b", outs(), 8'b10000_000);
    end
    quit_key = 1'b0; tick();
    n_tests++;
    if (outs() !== 8'b10000_000) begin
      n_fail++; $display("FAIL quit_release_idle: got %b want %b", outs(), 8'b10000_000);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); start_game();
`ifdef GAME_FLOW_CHANCE_EN
    misses(5, 1'b0);
`else
    misses(7, 1'b0);
`endif
    resetn = 1'b0; tick();
    n_tests++;
    if (outs() !== 8'b10000_000) begin
      n_fail++; $display("FAIL reset_mid_game: got %b want %b", outs(), 8'b10000_000);
    end
    n_tests++;
    if (dbg_state !== IDLE) begin
      n_fail++; $display("FAIL reset_mid_state: got %0d want %0d", dbg_state, IDLE);
    end
    resetn = 1'b1; tick();
    start_game();
`ifdef GAME_FLOW_CHANCE_EN
    misses(5, 1'b0);
    n_tests++;
    if (outs() !== 8'b01100_101) begin
      n_fail++; $display("FAIL chance_rearmed: got %b want %b", outs(), 8'b01100_101);
    end
`else
    misses(1, 1'b0);
    n_tests++;
    if (outs() !== 8'b01000_001) begin
      n_fail++; $display("FAIL count_after_reset: got %b want %b", outs(), 8'b01000_001);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_start();
`ifndef GAME_FLOW_CHANCE_EN
    test_normal_lose();
`else
    test_recover();
    test_timeout();
    test_both();
`endif
    test_master();
    test_held_level();
    test_done_win();
    test_quit_mid();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
